ieee_sqrt_iter: RTL and testbench

- Iterative, handshaked IEEE 754 square root for any binary format set by exponent/mantissa width parameters; successor to the fixed-latency pipelined sqrt wrapper.
- Radix-2 digit recurrence, one root bit per cycle; round-to-nearest-even; invalid/inexact flags; tag passthrough.
- Sits in the FP unit next to the pipelined FP operators, where area matters more than throughput.

---
 rtl/ieee_sqrt_iter.sv | 214 +++++++++++++++++++++
 tb/tb_ieee_sqrt_iter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ieee_sqrt_iter.sv
// ieee_sqrt_iter: iterative radix-2 IEEE 754 square root with round-to-nearest-even and a tag.
// Define IEEE_SQRT_SUBNORMAL_EN to normalise subnormal inputs; otherwise they are flushed to signed zero.
module ieee_sqrt_iter #(
    parameter int ExpWidth  = 8,
    parameter int ManWidth  = 23,
    parameter int TagWidth  = 4,
    parameter int DataWidth = 1 + ExpWidth + ManWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [DataWidth-1:0] operand_i,
    input  logic [TagWidth-1:0]  tag_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] result_o,
    output logic [TagWidth-1:0]  tag_o,
    output logic                 flag_nv_o,
    output logic                 flag_nx_o
);
    localparam int LzcW  = $clog2(ManWidth);
    localparam int EW    = ((ExpWidth > LzcW) ? ExpWidth : LzcW) + 2;
    localparam int RadW  = 2 * ManWidth + 4;
    localparam int RemW  = ManWidth + 4;
    localparam int RootW = ManWidth + 2;
    localparam int CntW  = $clog2(ManWidth + 2);
    localparam logic signed [EW-1:0] BiasS = EW'((1 << (ExpWidth - 1)) - 1);
    localparam logic [DataWidth-1:0] QNaN =
        {1'b0, {ExpWidth{1'b1}}, 1'b1, {(ManWidth-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, NORM, ITER, ROUND, DONE} state_t;

    state_t                  state, state_nxt;
    logic [CntW-1:0]         cnt;
    logic [RadW-1:0]         rad;
    logic [RemW-1:0]         rem;
    logic [RootW-1:0]        root;
    logic [ExpWidth-1:0]     res_exp;

    logic                    sgn;
    logic [ExpWidth-1:0]     e_fld;
    logic [ManWidth-1:0]     m_fld;
    logic                    spec_hit, spec_nv, go_norm;
    logic [DataWidth-1:0]    spec_res;
    logic                    ld_en, ld_odd;
    logic [ManWidth:0]       ld_sig;
    logic signed [EW-1:0]    ld_exp, ld_exp_adj;
    logic [RemW-1:0]         rem_sh, trial;
    logic                    ge;

    function automatic logic [ManWidth-1:0] round_rne(input logic [ManWidth:0] root_g,
                                                      input logic sticky);
        logic up;
        up = root_g[0] & (sticky | root_g[1]);
        return root_g[ManWidth:1] + ManWidth'(up);
    endfunction

    // Even unbiased exponent halves exactly; rebias for the result field.
    function automatic logic [ExpWidth-1:0] root_exp(input logic signed [EW-1:0] e_even);
        return ExpWidth'((e_even >>> 1) + BiasS);
    endfunction

`ifdef IEEE_SQRT_SUBNORMAL_EN
    logic [ManWidth-1:0] man_q;
    logic [LzcW-1:0]     lzc;

    function automatic logic [LzcW-1:0] lzc_f(input logic [ManWidth-1:0] m);
        lzc_f = '0;
        for (int i = 0; i < ManWidth; i++)
            if (m[i]) lzc_f = LzcW'(ManWidth - 1 - i);
    endfunction

    assign lzc = lzc_f(man_q);
`endif

    assign sgn         = operand_i[DataWidth-1];
    assign e_fld       = operand_i[DataWidth-2 -: ExpWidth];
    assign m_fld       = operand_i[ManWidth-1:0];
    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    always_comb begin
        spec_hit = 1'b0;
        spec_res = '0;
        spec_nv  = 1'b0;
        go_norm  = 1'b0;
        if (&e_fld) begin
            spec_hit = 1'b1;
            if (|m_fld) begin
                spec_res = QNaN;
                spec_nv  = ~m_fld[ManWidth-1];
            end else if (sgn) begin
                spec_res = QNaN;
                spec_nv  = 1'b1;
            end else begin
                spec_res = operand_i;
            end
        end else if (e_fld == '0 && m_fld == '0) begin
            spec_hit = 1'b1;
            spec_res = {sgn, {(DataWidth-1){1'b0}}};
        end else if (e_fld == '0) begin
`ifdef IEEE_SQRT_SUBNORMAL_EN
            if (sgn) begin
                spec_hit = 1'b1;
                spec_res = QNaN;
                spec_nv  = 1'b1;
            end else begin
                go_norm = 1'b1;
            end
`else
            spec_hit = 1'b1;
            spec_res = {sgn, {(DataWidth-1){1'b0}}};
`endif
        end else if (sgn) begin
            spec_hit = 1'b1;
            spec_res = QNaN;
            spec_nv  = 1'b1;
        end
    end

    // Operand load into the recurrence, from IDLE (normal) or NORM (normalised subnormal).
    always_comb begin
        ld_en  = (state == IDLE) && in_valid_i && !spec_hit && !go_norm;
        ld_sig = {1'b1, m_fld};
        ld_exp = $signed({{(EW-ExpWidth){1'b0}}, e_fld}) - BiasS;
`ifdef IEEE_SQRT_SUBNORMAL_EN
        if (state == NORM) begin
            ld_en  = 1'b1;
            ld_sig = {1'b1, (man_q << lzc) << 1};
            ld_exp = -BiasS - $signed({{(EW-LzcW){1'b0}}, lzc});
        end
`endif
    end

    assign ld_odd     = ld_exp[0];
    assign ld_exp_adj = ld_exp - $signed({{(EW-1){1'b0}}, ld_odd});

    assign rem_sh = {rem[RemW-3:0], rad[RadW-1 -: 2]};
    assign trial  = {root, 2'b01};
    assign ge     = (rem_sh >= trial);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid_i) begin
                    if (spec_hit)     state_nxt = DONE;
                    else if (go_norm) state_nxt = NORM;
                    else              state_nxt = ITER;
                end
            end
`ifdef IEEE_SQRT_SUBNORMAL_EN
            NORM:    state_nxt = ITER;
`endif
            ITER:    if (cnt == '0) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (ld_en)
                cnt <= CntW'(ManWidth + 1);
            else if (state == ITER && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    // Recurrence datapath: one root bit per ITER cycle.
    always_ff @(posedge clk_i) begin
        if (ld_en) begin
            rad     <= ld_odd ? {ld_sig, {(ManWidth+3){1'b0}}}
                              : {1'b0, ld_sig, {(ManWidth+2){1'b0}}};
            rem     <= '0;
            root    <= '0;
            res_exp <= root_exp(ld_exp_adj);
        end else if (state == ITER) begin
            rad  <= {rad[RadW-3:0], 2'b00};
            rem  <= ge ? (rem_sh - trial) : rem_sh;
            root <= {root[RootW-2:0], ge};
        end
`ifdef IEEE_SQRT_SUBNORMAL_EN
        if (state == IDLE && in_valid_i) man_q <= m_fld;
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_o  <= '0;
            tag_o     <= '0;
            flag_nv_o <= 1'b0;
            flag_nx_o <= 1'b0;
        end else if (state == IDLE && in_valid_i) begin
            tag_o <= tag_i;
            if (spec_hit) begin
                result_o  <= spec_res;
                flag_nv_o <= spec_nv;
                flag_nx_o <= 1'b0;
            end
        end else if (state == ROUND) begin
            result_o  <= {1'b0, res_exp, round_rne(root[ManWidth:0], |rem)};
            flag_nv_o <= 1'b0;
            flag_nx_o <= root[0] | (|rem);
        end
    end

endmodule

// File: tb/tb_ieee_sqrt_iter.sv
// tb_ieee_sqrt_iter: directed float32 vectors checked against a real-arithmetic sqrt model.
module tb_ieee_sqrt_iter;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        out_ready_i = 1'b1;
    logic [31:0] operand_i = '0;
    logic [3:0]  tag_i = '0;
    logic        in_ready_o, out_valid_o, flag_nv_o, flag_nx_o;
    logic [31:0] result_o;
    logic [3:0]  tag_o;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    ieee_sqrt_iter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .operand_i(operand_i), .tag_i(tag_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .result_o(result_o), .tag_o(tag_o),
        .flag_nv_o(flag_nv_o), .flag_nx_o(flag_nx_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

`ifdef IEEE_SQRT_SUBNORMAL_EN
    localparam bit          SubEn  = 1'b1;
    localparam logic [31:0] SubRes = 32'h1FB504F3;
    localparam bit          SubNx  = 1'b1;
    localparam int          SubLat = 28;
    localparam logic [31:0] NegSubRes = 32'h7FC00000;
    localparam bit          NegSubNv  = 1'b1;
`else
    localparam bit          SubEn  = 1'b0;
    localparam logic [31:0] SubRes = 32'h00000000;
    localparam bit          SubNx  = 1'b0;
    localparam int          SubLat = 1;
    localparam logic [31:0] NegSubRes = 32'h80000000;
    localparam bit          NegSubNv  = 1'b0;
`endif

    localparam int NV = 14;
    logic [31:0] vec_op [NV] = '{32'h40800000, 32'h40000000, 32'h3F800000, 32'hBF800000,
                                 32'h80000000, 32'h7F800000, 32'h7F800001, 32'h00400000,
                                 32'h41100000, 32'h00800000, 32'h7FC00000, 32'hFF800000,
                                 32'h3E800000, 32'h80400000};
    logic [31:0] vec_res [NV] = '{32'h40000000, 32'h3FB504F3, 32'h3F800000, 32'h7FC00000,
                                  32'h80000000, 32'h7F800000, 32'h7FC00000, SubRes,
                                  32'h40400000, 32'h20000000, 32'h7FC00000, 32'h7FC00000,
                                  32'h3F000000, NegSubRes};
    bit vec_nv [NV] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, NegSubNv};
    bit vec_nx [NV] = '{0, 1, 0, 0, 0, 0, 0, SubNx, 0, 0, 0, 0, 0, 0};
    int vec_lat [NV] = '{27, 27, 27, 1, 1, 1, 1, SubLat, 27, 27, 1, 1, 27, 1};

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %0s: got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference: IEEE rules for specials, real sqrt rounded RNE to float32 otherwise.
    function automatic void model(input logic [31:0] op, output logic [31:0] res,
                                  output logic nv, output logic nx, output int lat);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        real         x, r, rf;
        logic [63:0] b;
        logic [30:0] base;
        s = op[31]; e = op[30:23]; m = op[22:0];
        res = 32'h7FC00000; nv = 1'b0; nx = 1'b0; lat = 1;
        if (e == 8'hFF) begin
            if (m != 0)  nv = ~m[22];
            else if (s)  nv = 1'b1;
            else         res = op;
        end else if (e == 0 && m == 0) begin
            res = op;
        end else if (e == 0 && !SubEn) begin
            res = {s, 31'b0};
        end else if (s) begin
            nv = 1'b1;
        end else begin
            if (e == 0) begin
                x = $itor(m) * $bitstoreal({1'b0, 11'd874, 52'b0});
                lat = 28;
            end else begin
                x = $bitstoreal({1'b0, {3'b0, e} + 11'd896, m, 29'b0});
                lat = 27;
            end
            r = $sqrt(x);
            b = $realtobits(r);
            base = {8'(b[62:52] - 11'd896), b[51:29]};
            if (b[28] && ((|b[27:0]) || b[29])) base = base + 31'd1;
            res = {1'b0, base};
            rf = $bitstoreal({1'b0, {3'b0, base[30:23]} + 11'd896, base[22:0], 29'b0});
            nx = (rf * rf != x);
        end
    endfunction

    typedef struct {
        logic [31:0] res;
        logic        nv;
        logic        nx;
        logic [3:0]  tag;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t ne;
    bit   seen = 1'b0;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            sb.delete();
            seen = 1'b0;
        end else begin
            if (out_valid_o) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_valid: got result=%h, want no output", result_o);
                end else begin
                    check("result", result_o, sb[0].res);
                    check("tag", tag_o, sb[0].tag);
                    check("flags_nv_nx", {flag_nv_o, flag_nx_o}, {sb[0].nv, sb[0].nx});
                    if (!seen) check("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                    seen = 1'b1;
                    if (out_ready_i) begin
                        void'(sb.pop_front());
                        seen = 1'b0;
                    end
                end
            end
            if (in_valid_i && in_ready_o) begin
                model(operand_i, ne.res, ne.nv, ne.nx, ne.lat);
                ne.tag = tag_i;
                ne.acc = cyc;
                sb.push_back(ne);
            end
        end
    end

    task automatic send(input logic [31:0] op, input logic [3:0] tg);
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; operand_i = op; tag_i = tg;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_i);
            if (in_ready_o) begin
                @(posedge clk_i); #1;
                in_valid_i = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL send_timeout: operand %h not accepted, want accept within 200 cycles", op);
        in_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_i);
            if (out_valid_o && out_ready_i) begin
                @(posedge clk_i); #1;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL done_timeout: no result, want one within %0d cycles", budget);
    endtask

    logic [31:0] mr;
    logic        mnv, mnx;
    int          mlat;
    bit          got_valid;

    initial begin
        for (int i = 0; i < NV; i++) begin
            model(vec_op[i], mr, mnv, mnx, mlat);
            check("model_pin", {30'b0, mr, mnv, mnx}, {30'b0, vec_res[i], vec_nv[i], vec_nx[i]});
            check("model_lat", 64'(mlat), 64'(vec_lat[i]));
        end

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_in_ready", in_ready_o, 1);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_result", result_o, 0);
        check("rst_tag", tag_o, 0);
        check("rst_flags", {flag_nv_o, flag_nx_o}, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;

        for (int i = 0; i < NV; i++) begin
            send(vec_op[i], 4'(i));
            wait_done(60);
        end

        for (int i = 0; i < 20; i++) begin
            send({1'b0, 8'($urandom_range(1, 254)), 23'($urandom)}, 4'($urandom));
            wait_done(60);
        end

        // Backpressure: result held in DONE while a competing operand is offered.
        out_ready_i = 1'b0;
        send(32'h3F800000, 4'hA);
        got_valid = 1'b0;
        for (int i = 0; i < 60 && !got_valid; i++) begin
            @(negedge clk_i);
            got_valid = out_valid_o;
        end
        if (!got_valid) begin
            checks++; errors++;
            $display("FAIL bp_valid_timeout: out_valid_o=0, want 1 within 60 cycles");
        end
        @(posedge clk_i); #1;
        in_valid_i = 1'b1; operand_i = 32'h40800000; tag_i = 4'h5;
        repeat (10) begin
            @(negedge clk_i);
            check("bp_in_ready", in_ready_o, 0);
            check("bp_out_valid", out_valid_o, 1);
        end
        @(posedge clk_i); #1;
        out_ready_i = 1'b1; in_valid_i = 1'b0;
        @(posedge clk_i); #1;
        check("bp_release_in_ready", in_ready_o, 1);
        check("bp_release_out_valid", out_valid_o, 0);
        check("bp_one_transfer", 64'(sb.size()), 0);

        // Reset in the middle of the recurrence.
        send(32'h40800000, 4'h3);
        repeat (9) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        @(negedge clk_i);
        check("abort_out_valid", out_valid_o, 0);
        check("abort_in_ready", in_ready_o, 1);
        check("abort_result", result_o, 0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        repeat (30) @(negedge clk_i);
        check("abort_idle_ready", in_ready_o, 1);
        send(32'h40800000, 4'h6);
        wait_done(60);
        check("abort_next_result", result_o, 32'h40000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
